muldiv_iter: RTL and testbench

Iterative multiply/divide unit for the RV32M instructions (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU), parametrised in WIDTH.
It sits beside the single-cycle ALU in the EXU, with a valid/ready handshake on both sides, and lets the pipeline stall on multi-cycle M-ops.
Core is radix-2: one shift-add (multiply) or one restore-subtract (divide) step per cycle on magnitudes, then one sign-fix cycle.
Divide-by-zero and signed overflow finish early.

---
 rtl/muldiv_pkg.sv | 35 +++
 rtl/muldiv_iter_if.sv | 26 ++
 rtl/mdu_addsub.sv | 16 +
 rtl/muldiv_iter.sv | 134 +++++++++++++
 tb/tb_muldiv_iter.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and op decode helpers for the iterative RV32M multiply/divide unit.
// Pure declarations: no latency, no flow control.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_e;

  function automatic logic is_div(input muldiv_op_e op);
    return op[2];
  endfunction

  function automatic logic src1_signed(input muldiv_op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic src2_signed(input muldiv_op_e op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/muldiv_iter_if.sv
// Request/response bundle between the EXU and the multiply/divide unit.
// Valid/ready on both sides; flush aborts whatever is in flight.
interface muldiv_iter_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             busy;

  modport master (
    output in_valid, op, src1, src2, flush, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, op, src1, src2, flush, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/mdu_addsub.sv
// WIDTH+1-bit adder/subtractor with carry-out, shared by multiply and divide steps.
// Combinational; no flow control. When subtracting, cout=1 means a >= b.
module mdu_addsub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0] a,
  input  logic [WIDTH:0] b,
  input  logic           sub,
  output logic [WIDTH:0] sum,
  output logic           cout
);
  logic [WIDTH:0] b_eff;

  assign b_eff = sub ? ~b : b;
  assign {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{(WIDTH + 1){1'b0}}, sub};
endmodule

// File: rtl/muldiv_iter.sv
// Radix-2 iterative RV32M mul/div: WIDTH step cycles on magnitudes plus one sign-fix cycle.
// Result after WIDTH+2 cycles (1 for div-by-zero/overflow); in_ready only in IDLE, result held until out_ready.
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          rst_n,
  muldiv_iter_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH - 1){1'b0}}};

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  muldiv_op_e       op_q;
  logic             neg_q, rneg_q;
  logic [WIDTH-1:0] acc_q, lo_q, opb_q, result_q;

  muldiv_op_e       op_in;
  logic             s1_neg, s2_neg, div_zero, div_ovf, early, accept;
  logic [WIDTH-1:0] mag1, mag2, early_res, fix_res;

  always_comb begin
    op_in     = muldiv_op_e'(bus.op);
    s1_neg    = src1_signed(op_in) & bus.src1[WIDTH-1];
    s2_neg    = src2_signed(op_in) & bus.src2[WIDTH-1];
    mag1      = s1_neg ? -bus.src1 : bus.src1;
    mag2      = s2_neg ? -bus.src2 : bus.src2;
    div_zero  = is_div(op_in) && (bus.src2 == '0);
    div_ovf   = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                (bus.src1 == MIN_VAL) && (bus.src2 == '1);
    early     = div_zero | div_ovf;
    early_res = '0;
    if (div_zero)
      early_res = op_in[1] ? bus.src1 : '1;
    else if (div_ovf)
      early_res = (op_in == OP_DIV) ? MIN_VAL : '0;
    accept    = bus.in_valid && (state_q == IDLE) && !bus.flush;
  end

  // Divide shifts the next dividend bit into the partial remainder before the trial subtract.
  logic             op_div, add_cout;
  logic [WIDTH:0]   div_shift, add_a, add_b, add_sum;

  always_comb begin
    op_div    = is_div(op_q);
    div_shift = {acc_q, lo_q[WIDTH-1]};
    add_a     = op_div ? div_shift : {1'b0, acc_q};
    add_b     = (op_div || lo_q[0]) ? {1'b0, opb_q} : '0;
  end

  mdu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a    (add_a),
    .b    (add_b),
    .sub  (op_div),
    .sum  (add_sum),
    .cout (add_cout)
  );

  logic [2*WIDTH-1:0] prod, prod_fix;

  always_comb begin
    prod     = {acc_q, lo_q};
    prod_fix = neg_q ? -prod : prod;
    fix_res  = '0;
    case (op_q)
      OP_MUL:                      fix_res = prod_fix[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_fix[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:             fix_res = neg_q ? -lo_q : lo_q;
      default:                     fix_res = rneg_q ? -acc_q : acc_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = early ? DONE : CALC;
      CALC: if (cnt_q == CW'(1)) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.flush && (state_q != IDLE))
      state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      op_q     <= OP_MUL;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      acc_q    <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      result_q <= '0;
    end else if (accept) begin
      cnt_q  <= CW'(WIDTH);
      op_q   <= op_in;
      neg_q  <= s1_neg ^ s2_neg;
      rneg_q <= s1_neg;
      acc_q  <= '0;
      lo_q   <= is_div(op_in) ? mag1 : mag2;
      opb_q  <= is_div(op_in) ? mag2 : mag1;
      if (early)
        result_q <= early_res;
    end else if (state_q == CALC) begin
      cnt_q <= cnt_q - CW'(1);
      if (op_div) begin
        acc_q <= add_cout ? add_sum[WIDTH-1:0] : div_shift[WIDTH-1:0];
        lo_q  <= {lo_q[WIDTH-2:0], add_cout};
      end else begin
        acc_q <= add_sum[WIDTH:1];
        lo_q  <= {add_sum[0], lo_q[WIDTH-1:1]};
      end
    end else if ((state_q == FIX) && !bus.flush) begin
      result_q <= fix_res;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.result    = result_q;
endmodule

// File: tb/tb_muldiv_iter.sv
// Randomised + directed bench for muldiv_iter against a plain-arithmetic RV32M model.
// A cycle monitor tracks the one outstanding request and checks handshake, latency and result.
module tb_muldiv_iter;
  localparam int W = 32;
  localparam logic [31:0] MINV = 32'h8000_0000;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  muldiv_iter_if #(.WIDTH(W)) bus ();

  muldiv_iter #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp)
      n_pass++;
    else
      $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // RV32M semantics from 64-bit arithmetic; SV division truncates toward zero like RISC-V.
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'h0, b});
    p  = '0;
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
      3'd4: begin if (b == 0) return '1; p = sa / sb; return p[31:0]; end
      3'd5: begin if (b == 0) return '1; return a / b; end
      3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
      default: begin if (b == 0) return a; return a % b; end
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && (b == 0 || (!op[0] && a == MINV && b == '1)))
      return 1;
    return W + 2;
  endfunction

  // Monitor: one request in flight at most; age counts cycles since the accept edge.
  logic        m_act = 1'b0;
  logic [31:0] m_res;
  int          m_lat, m_age;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act = 1'b0;
    end else if (m_act) begin
      if (bus.flush || (bus.out_valid && bus.out_ready))
        m_act = 1'b0;
      else
        m_age++;
    end else if (bus.in_valid && bus.in_ready && !bus.flush) begin
      m_act = 1'b1;
      m_age = 1;
      m_res = model(bus.op, bus.src1, bus.src2);
      m_lat = model_lat(bus.op, bus.src1, bus.src2);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (m_act) begin
        check("mon_busy_valid", {62'b0, bus.in_ready, bus.busy},
              64'(2'b01));
        check("mon_out_valid", 64'(bus.out_valid), 64'(m_age >= m_lat));
        if (bus.out_valid)
          check("mon_result", 64'(bus.result), 64'(m_res));
      end else begin
        check("mon_idle", {61'b0, bus.in_ready, bus.busy, bus.out_valid}, 64'(3'b100));
      end
    end
  end

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int stall, output logic [31:0] res, output int lat);
    res = '0;
    lat = 0;
    bus.op        = op;
    bus.src1      = a;
    bus.src2      = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = (stall == 0);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        lat = i;
        res = bus.result;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (stall > 0) begin
      repeat (stall) @(posedge clk);
      #1 bus.out_ready = 1'b1;
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  task automatic directed(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    logic [31:0] r;
    int          l;
    run_op(op, a, b, 0, r, l);
    check({name, "_result"}, 64'(r), 64'(exp));
    check({name, "_latency"}, 64'(l), 64'(exp_lat));
  endtask

  // Abort a request during cycle k after its accept edge.
  task automatic run_flush(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int k);
    bus.op        = op;
    bus.src1      = a;
    bus.src2      = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (k - 1) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    @(negedge clk);
    check("flush_idle", {62'b0, bus.busy, bus.out_valid}, 64'(0));
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_opnd();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0: v = 32'h0;
      1: v = 32'hFFFF_FFFF;
      2: v = MINV;
      3: v = $urandom_range(0, 15);
      4: begin v = $urandom_range(1, 15); v = -v; end
      default: v = $urandom();
    endcase
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    int          l;

    bus.in_valid  = 1'b0;
    bus.op        = 3'd0;
    bus.src1      = '0;
    bus.src2      = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("reset_in_ready", 64'(bus.in_ready), 64'(1));
    check("reset_out_valid", 64'(bus.out_valid), 64'(0));
    check("reset_busy", 64'(bus.busy), 64'(0));
    check("reset_result", 64'(bus.result), 64'(0));
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    directed("mul_7x-3",    3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
    directed("mulh_min",    3'd1, MINV, MINV, 32'h4000_0000, 34);
    directed("mulhsu_min",  3'd2, MINV, MINV, 32'hC000_0000, 34);
    directed("mulhu_min",   3'd3, MINV, MINV, 32'h4000_0000, 34);
    directed("div_-7_2",    3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    directed("rem_-7_2",    3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    directed("divu_100_7",  3'd5, 32'd100, 32'd7, 32'd14, 34);
    directed("remu_100_7",  3'd7, 32'd100, 32'd7, 32'd2, 34);
    directed("div_by_zero", 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    directed("remu_by_zero",3'd7, 32'd5, 32'd0, 32'd5, 1);
    directed("div_ovf",     3'd4, MINV, 32'hFFFF_FFFF, MINV, 1);
    directed("rem_ovf",     3'd6, MINV, 32'hFFFF_FFFF, 32'd0, 1);

    // Consumer stalls for 10 cycles; the monitor checks stability throughout.
    run_op(3'd5, 32'd100, 32'd7, 10, r, l);
    check("stall_result", 64'(r), 64'(14));
    @(negedge clk);
    check("stall_release_idle", 64'(bus.in_ready), 64'(1));
    @(posedge clk);
    #1;

    run_flush(3'd4, 32'd1000, 32'd3, 10);
    directed("mul_after_flush", 3'd0, 32'd3, 32'd4, 32'd12, 34);

    // flush beats in_valid in IDLE.
    bus.op = 3'd0; bus.src1 = 32'd9; bus.src2 = 32'd9;
    bus.in_valid = 1'b1;
    bus.flush    = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    bus.flush = 1'b0;
    @(negedge clk);
    check("idle_flush_no_accept", 64'(bus.busy), 64'(0));
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of CALC.
    bus.op = 3'd0; bus.src1 = 32'd5; bus.src2 = 32'd6;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_in_ready", 64'(bus.in_ready), 64'(1));
    check("arst_out_valid", 64'(bus.out_valid), 64'(0));
    check("arst_busy", 64'(bus.busy), 64'(0));
    check("arst_result", 64'(bus.result), 64'(0));
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int n = 0; n < 200; n++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom_range(0, 7));
      a  = rand_opnd();
      b  = rand_opnd();
      if ($urandom_range(0, 9) == 0) begin
        run_flush(op, a, b, $urandom_range(1, 34));
      end else begin
        run_op(op, a, b, $urandom_range(0, 3), r, l);
        check("rand_completed", 64'(l != 0), 64'(1));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
